// File: rtl/seg7_capture.sv
// Receive-side decoder for a scanned 7-segment bus: synchronizes, debounces each
// digit dwell, decodes segments back to BCD and assembles four slots into a frame.
module seg7_capture #(
    parameter int          SETTLE  = 16,
    parameter logic [23:0] TIMEOUT = 24'd1000000
) (
    input  logic       clk0,
    input  logic       rst_n,
    input  logic [7:0] seg7,
    input  logic [3:0] line,
    input  logic       clr,
    output logic [3:0] digit0,
    output logic [3:0] digit1,
    output logic [3:0] digit2,
    output logic [3:0] digit3,
    output logic [3:0] blank,
    output logic       frame_stb,
    output logic       link_ok,
    output logic       err_seg,
    output logic       err_line
);
    localparam logic [7:0]  CNT_CAP = 8'(SETTLE - 2);
    localparam logic [7:0]  CNT_MAX = 8'(SETTLE);
    localparam logic [23:0] TO_LAST = TIMEOUT - 24'd1;

    logic [6:0]       r_seg_m, r_seg_s, r_seg_p;
    logic [3:0]       r_line_m, r_line_s, r_line_p;
    logic [7:0]       r_cnt;
    logic [23:0]      r_to;
    logic [3:0]       r_seen;
    logic [3:0][3:0]  r_stage;
    logic [3:0]       r_stage_blank;
    logic [3:0][3:0]  r_digit;
    logic [3:0]       r_blank;
    logic             r_frame_stb, r_link_ok, r_err_seg, r_err_line;

    logic       w_same, w_cap, w_onehot, w_cap_ok, w_to_hit;
    logic [3:0] w_code;
    logic       w_unused_dp;

    assign w_unused_dp = seg7[7];
    assign w_same   = (r_seg_s == r_seg_p) && (r_line_s == r_line_p);
    // Registered update lands on the edge where cnt becomes SETTLE-1.
    assign w_cap    = w_same && (r_cnt == CNT_CAP);
    assign w_onehot = (r_line_s != 4'd0) && ((r_line_s & (r_line_s - 4'd1)) == 4'd0);
    assign w_cap_ok = w_cap && w_onehot;
    assign w_to_hit = !w_cap_ok && (r_to == TO_LAST);

    always_comb begin
        w_code = 4'hE;
        case (r_seg_s)
            7'h3F:   w_code = 4'd0;
            7'h06:   w_code = 4'd1;
            7'h5B:   w_code = 4'd2;
            7'h4F:   w_code = 4'd3;
            7'h66:   w_code = 4'd4;
            7'h6D:   w_code = 4'd5;
            7'h7D:   w_code = 4'd6;
            7'h27:   w_code = 4'd7;
            7'h7F:   w_code = 4'd8;
            7'h6F:   w_code = 4'd9;
            7'h00:   w_code = 4'hF;
            default: w_code = 4'hE;
        endcase
    end

    always_ff @(posedge clk0 or negedge rst_n) begin
        if (!rst_n) begin
            r_seg_m  <= '0;
            r_seg_s  <= '0;
            r_seg_p  <= '0;
            r_line_m <= '0;
            r_line_s <= '0;
            r_line_p <= '0;
            r_cnt    <= '0;
        end else begin
            r_seg_m  <= seg7[6:0];
            r_seg_s  <= r_seg_m;
            r_seg_p  <= r_seg_s;
            r_line_m <= line;
            r_line_s <= r_line_m;
            r_line_p <= r_line_s;
            if (!w_same)
                r_cnt <= '0;
            else if (r_cnt != CNT_MAX)
                r_cnt <= r_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk0 or negedge rst_n) begin
        if (!rst_n) begin
            r_stage       <= '0;
            r_stage_blank <= '0;
        end else if (w_cap_ok) begin
            for (int k = 0; k < 4; k++) begin
                if (r_line_s[k]) begin
                    r_stage[k]       <= w_code;
                    r_stage_blank[k] <= (r_seg_s == 7'd0);
                end
            end
        end
    end

    // A capture can never coincide with seen==4'hF because SETTLE >= 2.
    always_ff @(posedge clk0 or negedge rst_n) begin
        if (!rst_n) begin
            r_seen      <= '0;
            r_to        <= '0;
            r_digit     <= '0;
            r_blank     <= '0;
            r_frame_stb <= 1'b0;
            r_link_ok   <= 1'b0;
        end else begin
            r_frame_stb <= 1'b0;
            if (w_cap_ok)
                r_to <= '0;
            else if (r_to != TIMEOUT)
                r_to <= r_to + 24'd1;

            if (r_seen == 4'hF) begin
                r_seen      <= '0;
                r_digit     <= r_stage;
                r_blank     <= r_stage_blank;
                r_frame_stb <= 1'b1;
                r_link_ok   <= 1'b1;
            end else if (w_cap_ok) begin
                r_seen <= r_seen | r_line_s;
            end else if (w_to_hit) begin
                r_seen    <= '0;
                r_link_ok <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk0 or negedge rst_n) begin
        if (!rst_n) begin
            r_err_seg  <= 1'b0;
            r_err_line <= 1'b0;
        end else begin
            if (w_cap && (w_code == 4'hE))
                r_err_seg <= 1'b1;
            else if (clr)
                r_err_seg <= 1'b0;
            if (w_cap && !w_onehot)
                r_err_line <= 1'b1;
            else if (clr)
                r_err_line <= 1'b0;
        end
    end

    assign digit0    = r_digit[0];
    assign digit1    = r_digit[1];
    assign digit2    = r_digit[2];
    assign digit3    = r_digit[3];
    assign blank     = r_blank;
    assign frame_stb = r_frame_stb;
    assign link_ok   = r_link_ok;
    assign err_seg   = r_err_seg;
    assign err_line  = r_err_line;
endmodule

// File: tb/tb_seg7_capture.sv
// Bench for seg7_capture: directed scenarios plus random dwell sequences
// compared against a dwell-level frame assembly model.
module tb_seg7_capture;
    localparam int          SETTLE  = 4;
    localparam logic [23:0] TIMEOUT = 24'd64;
    localparam logic [6:0]  PAT [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                         7'h6D, 7'h7D, 7'h27, 7'h7F, 7'h6F};

    logic       clk0 = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] seg7 = '0;
    logic [3:0] line = 4'b0001;
    logic       clr = 1'b0;
    logic [3:0] digit0, digit1, digit2, digit3, blank;
    logic       frame_stb, link_ok, err_seg, err_line;

    int n_chk = 0;
    int n_fail = 0;
    int stb_cnt = 0;
    logic [19:0] obs_q[$];
    logic [19:0] exp_q[$];

    // dwell-level model state
    int         m_code [4];
    logic [3:0] m_blank;
    logic [3:0] m_seen;
    logic [10:0] m_prev;
    logic       m_err_seg;

    seg7_capture #(.SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
        .clk0(clk0), .rst_n(rst_n), .seg7(seg7), .line(line), .clr(clr),
        .digit0(digit0), .digit1(digit1), .digit2(digit2), .digit3(digit3),
        .blank(blank), .frame_stb(frame_stb), .link_ok(link_ok),
        .err_seg(err_seg), .err_line(err_line)
    );

    always #5 clk0 = ~clk0;

    always @(negedge clk0) begin
        if (rst_n === 1'b1 && frame_stb === 1'b1) begin
            stb_cnt++;
            obs_q.push_back({blank, digit3, digit2, digit1, digit0});
        end
    end

    function automatic int model_code(input logic [6:0] p);
        for (int i = 0; i < 10; i++)
            if (PAT[i] == p) return i;
        if (p == 7'd0) return 15;
        return 14;
    endfunction

    task automatic model_reset();
        m_seen = '0;
        m_prev = '0;
        m_err_seg = 1'b0;
        m_blank = '0;
        for (int i = 0; i < 4; i++) m_code[i] = 0;
        exp_q.delete();
    endtask

    task automatic model_capture(input logic [3:0] ln, input logic [6:0] pat);
        logic [19:0] fr;
        if (model_code(pat) == 14) m_err_seg = 1'b1;
        if ($countones(ln) != 1) return;
        for (int k = 0; k < 4; k++) begin
            if (ln[k]) begin
                m_code[k] = model_code(pat);
                m_blank[k] = (pat == 7'd0);
                m_seen[k] = 1'b1;
            end
        end
        if (m_seen == 4'hF) begin
            fr = {m_blank, 4'(m_code[3]), 4'(m_code[2]), 4'(m_code[1]), 4'(m_code[0])};
            exp_q.push_back(fr);
            m_seen = '0;
        end
    endtask

    // Drive one dwell starting just after a rising edge; leaves time just after a rising edge.
    task automatic drive(input logic [3:0] ln, input logic [6:0] pat, input int len);
        seg7 = {1'($urandom_range(0, 1)), pat};
        line = ln;
        if ({pat, ln} != m_prev && len >= SETTLE) model_capture(ln, pat);
        m_prev = {pat, ln};
        repeat (len) begin
            @(posedge clk0);
            #1;
        end
    endtask

    task automatic test_reset();
        model_reset();
        rst_n = 1'b0;
        line = 4'b0001;
        seg7 = '0;
        clr = 1'b0;
        #17;
        n_chk++;
        if ({digit3, digit2, digit1, digit0, blank, frame_stb, link_ok, err_seg, err_line} !== 24'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h required 0",
                     {digit3, digit2, digit1, digit0, blank, frame_stb, link_ok, err_seg, err_line});
        end
        @(negedge clk0) rst_n = 1'b1;
        @(posedge clk0) #1;
        drive(4'b0001, 7'd0, 8);
        n_chk++;
        if (link_ok !== 1'b0 || stb_cnt !== 0) begin
            n_fail++;
            $display("FAIL reset_no_frame: link_ok=%b stb=%0d required 0/0", link_ok, stb_cnt);
        end
    endtask

    task automatic test_clean_scan();
        int s0, lat;
        s0 = stb_cnt;
        lat = 0;
        drive(4'b0001, PAT[1], 8);
        drive(4'b0010, PAT[2], 8);
        drive(4'b0100, PAT[3], 8);
        line = 4'b1000;
        seg7 = {1'b0, PAT[4]};
        m_prev = {PAT[4], 4'b1000};
        for (int n = 1; n <= 10; n++) begin
            @(posedge clk0);
            #1;
            if (frame_stb === 1'b1 && lat == 0) lat = n;
        end
        n_chk++;
        if (lat !== 7) begin
            n_fail++;
            $display("FAIL clean_latency: got %0d required 7", lat);
        end
        n_chk++;
        if (stb_cnt - s0 !== 1) begin
            n_fail++;
            $display("FAIL clean_stb_count: got %0d required 1", stb_cnt - s0);
        end
        n_chk++;
        if ({digit3, digit2, digit1, digit0} !== 16'h4321 || link_ok !== 1'b1) begin
            n_fail++;
            $display("FAIL clean_digits: got %h link=%b required 4321 link=1",
                     {digit3, digit2, digit1, digit0}, link_ok);
        end
        n_chk++;
        if (err_seg !== 1'b0 || err_line !== 1'b0 || blank !== 4'd0) begin
            n_fail++;
            $display("FAIL clean_errors: got seg=%b line=%b blank=%b required 0", err_seg, err_line, blank);
        end
    endtask

    task automatic test_glitch();
        int s0;
        s0 = stb_cnt;
        drive(4'b0001, 7'h06, 3);
        drive(4'b0001, 7'h5B, 8);
        drive(4'b0010, PAT[5], 8);
        drive(4'b0100, PAT[6], 8);
        drive(4'b1000, PAT[7], 8);
        n_chk++;
        if (stb_cnt - s0 !== 1 || {digit3, digit2, digit1, digit0} !== 16'h7652) begin
            n_fail++;
            $display("FAIL glitch_reject: got %h stb=%0d required 7652 stb=1",
                     {digit3, digit2, digit1, digit0}, stb_cnt - s0);
        end
    endtask

    task automatic test_illegal();
        int s0;
        s0 = stb_cnt;
        drive(4'b0001, PAT[0], 8);
        drive(4'b0010, PAT[1], 8);
        drive(4'b1000, PAT[9], 8);
        drive(4'b0100, 7'h55, 8);
        n_chk++;
        if (digit2 !== 4'hE || err_seg !== 1'b1 || err_line !== 1'b0 || stb_cnt - s0 !== 1) begin
            n_fail++;
            $display("FAIL illegal_seg: got d2=%h seg=%b line=%b required E/1/0", digit2, err_seg, err_line);
        end
        s0 = stb_cnt;
        drive(4'b0011, PAT[7], 8);
        n_chk++;
        if (err_line !== 1'b1) begin
            n_fail++;
            $display("FAIL illegal_line: got %b required 1", err_line);
        end
        drive(4'b0001, PAT[3], 8);
        drive(4'b0010, PAT[3], 8);
        drive(4'b0100, PAT[3], 8);
        n_chk++;
        if (stb_cnt - s0 !== 0) begin
            n_fail++;
            $display("FAIL illegal_line_seen: got %0d frames required 0", stb_cnt - s0);
        end
        drive(4'b1000, PAT[3], 8);
        n_chk++;
        if (stb_cnt - s0 !== 1 || {digit3, digit2, digit1, digit0} !== 16'h3333) begin
            n_fail++;
            $display("FAIL illegal_line_frame: got %h stb=%0d required 3333 stb=1",
                     {digit3, digit2, digit1, digit0}, stb_cnt - s0);
        end
        clr = 1'b1;
        @(posedge clk0) #1;
        clr = 1'b0;
        n_chk++;
        if (err_seg !== 1'b0 || err_line !== 1'b0) begin
            n_fail++;
            $display("FAIL clr_clears: got seg=%b line=%b required 0/0", err_seg, err_line);
        end
        // clr held in exactly the cycle whose closing edge captures 0x55
        line = 4'b0100;
        seg7 = {1'b0, 7'h55};
        m_prev = {7'h55, 4'b0100};
        repeat (5) begin
            @(posedge clk0);
            #1;
        end
        clr = 1'b1;
        @(posedge clk0) #1;
        clr = 1'b0;
        n_chk++;
        if (err_seg !== 1'b1) begin
            n_fail++;
            $display("FAIL clr_set_wins: got %b required 1", err_seg);
        end
        repeat (3) @(posedge clk0);
        #1;
    endtask

    task automatic test_blank_overwrite();
        int s0;
        s0 = stb_cnt;
        drive(4'b0010, PAT[5], 8);
        drive(4'b1000, 7'd0, 8);
        drive(4'b0010, PAT[9], 8);
        drive(4'b0001, PAT[0], 8);
        n_chk++;
        if (stb_cnt - s0 !== 1 || digit3 !== 4'hF || blank !== 4'b1000) begin
            n_fail++;
            $display("FAIL blank_slot3: got d3=%h blank=%b stb=%0d required F/1000/1", digit3, blank, stb_cnt - s0);
        end
        n_chk++;
        if (digit1 !== 4'd9 || digit0 !== 4'd0 || digit2 !== 4'hE) begin
            n_fail++;
            $display("FAIL overwrite_slot1: got %h required FE90", {digit3, digit2, digit1, digit0});
        end
    endtask

    task automatic test_timeout();
        int s0;
        drive(4'b0001, PAT[1], 8);
        drive(4'b0010, PAT[2], 8);
        drive(4'b0100, PAT[3], 8);
        line = 4'b1000;
        seg7 = {1'b0, PAT[4]};
        m_prev = {PAT[4], 4'b1000};
        repeat (69) @(posedge clk0);
        #1;
        n_chk++;
        if (link_ok !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_early: got link_ok=%b required 1", link_ok);
        end
        @(posedge clk0) #1;
        n_chk++;
        if (link_ok !== 1'b0 || {digit3, digit2, digit1, digit0} !== 16'h4321) begin
            n_fail++;
            $display("FAIL timeout_drop: got link=%b digits=%h required 0/4321",
                     link_ok, {digit3, digit2, digit1, digit0});
        end
        s0 = stb_cnt;
        drive(4'b0001, PAT[5], 8);
        drive(4'b0010, PAT[6], 8);
        drive(4'b0100, PAT[7], 8);
        n_chk++;
        if (stb_cnt - s0 !== 0 || link_ok !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_three: got stb=%0d link=%b required 0/0", stb_cnt - s0, link_ok);
        end
        drive(4'b1000, PAT[8], 8);
        n_chk++;
        if (stb_cnt - s0 !== 1 || link_ok !== 1'b1 || {digit3, digit2, digit1, digit0} !== 16'h8765) begin
            n_fail++;
            $display("FAIL timeout_fourth: got stb=%0d link=%b digits=%h required 1/1/8765",
                     stb_cnt - s0, link_ok, {digit3, digit2, digit1, digit0});
        end
        // a partial frame abandoned by timeout must not complete later
        s0 = stb_cnt;
        drive(4'b0001, PAT[8], 76);
        drive(4'b0010, PAT[1], 8);
        drive(4'b0100, PAT[1], 8);
        drive(4'b1000, PAT[1], 8);
        n_chk++;
        if (stb_cnt - s0 !== 0) begin
            n_fail++;
            $display("FAIL timeout_clears_seen: got %0d frames required 0", stb_cnt - s0);
        end
        drive(4'b0001, PAT[1], 8);
        n_chk++;
        if (stb_cnt - s0 !== 1 || {digit3, digit2, digit1, digit0} !== 16'h1111) begin
            n_fail++;
            $display("FAIL timeout_refill: got stb=%0d digits=%h required 1/1111",
                     stb_cnt - s0, {digit3, digit2, digit1, digit0});
        end
    endtask

    task automatic test_reset_mid();
        int s0;
        drive(4'b0001, PAT[1], 8);
        drive(4'b0010, PAT[2], 8);
        rst_n = 1'b0;
        #2;
        n_chk++;
        if ({digit3, digit2, digit1, digit0, blank, frame_stb, link_ok, err_seg, err_line} !== 24'd0) begin
            n_fail++;
            $display("FAIL reset_mid_async: got %h required 0",
                     {digit3, digit2, digit1, digit0, blank, frame_stb, link_ok, err_seg, err_line});
        end
        model_reset();
        line = 4'b0001;
        seg7 = {1'b0, PAT[3]};
        @(negedge clk0) rst_n = 1'b1;
        @(posedge clk0) #1;
        s0 = stb_cnt;
        drive(4'b0001, PAT[3], 8);
        drive(4'b0010, PAT[4], 8);
        drive(4'b0100, PAT[5], 8);
        n_chk++;
        if (stb_cnt - s0 !== 0) begin
            n_fail++;
            $display("FAIL reset_mid_partial: got %0d frames required 0", stb_cnt - s0);
        end
        drive(4'b1000, PAT[6], 8);
        n_chk++;
        if (stb_cnt - s0 !== 1 || {digit3, digit2, digit1, digit0} !== 16'h6543 || err_line !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_frame: got stb=%0d digits=%h err_line=%b required 1/6543/0",
                     stb_cnt - s0, {digit3, digit2, digit1, digit0}, err_line);
        end
    endtask

    task automatic test_random();
        logic [3:0] ln;
        logic [6:0] pt;
        int len, r;
        rst_n = 1'b0;
        line = 4'b0001;
        seg7 = '0;
        #3;
        model_reset();
        obs_q.delete();
        @(negedge clk0) rst_n = 1'b1;
        @(posedge clk0) #1;
        drive(4'b0001, 7'd0, 8);
        for (int i = 0; i < 250; i++) begin
            ln = 4'b0001 << $urandom_range(0, 3);
            r = $urandom_range(0, 99);
            if (r < 75) pt = PAT[$urandom_range(0, 9)];
            else if (r < 85) pt = 7'd0;
            else pt = 7'($urandom);
            len = ($urandom_range(0, 99) < 15) ? $urandom_range(1, 3) : $urandom_range(4, 10);
            if ({pt, ln} == m_prev) ln = {ln[2:0], ln[3]};
            drive(ln, pt, len);
        end
        drive(4'b0100, PAT[$urandom_range(0, 9)], 8);
        repeat (4) @(posedge clk0);
        #1;
        n_chk++;
        if (obs_q.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL random_frame_count: got %0d required %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_chk++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL random_frame[%0d]: got %h required %h", i, obs_q[i], exp_q[i]);
            end
        end
        n_chk++;
        if (err_seg !== m_err_seg || err_line !== 1'b0) begin
            n_fail++;
            $display("FAIL random_errors: got seg=%b line=%b required %b/0", err_seg, err_line, m_err_seg);
        end
        n_chk++;
        if (link_ok !== (exp_q.size() > 0)) begin
            n_fail++;
            $display("FAIL random_link: got %b required %b", link_ok, exp_q.size() > 0);
        end
    endtask

    initial begin
        test_reset();
        test_clean_scan();
        test_glitch();
        test_illegal();
        test_blank_overwrite();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
